axi_lite_slave_mem: RTL
=======================

Name: axi_lite_slave_mem

Overview:
- Parametrised AXI4-Lite slave with a byte-addressed local memory. Full write path (AW/W/B) and read path (AR/R).
- Successor to the single-channel write slave: independent AW/W acceptance, 2-bit responses, SLVERR on out-of-range access, configurable data width and memory depth.
- Sits behind the interconnect as the generic register/scratch-RAM endpoint.

Parameters:
- DATA_WIDTH, 32, bus data width in bits; must be 32 or 64. STRB width = DATA_WIDTH/8.
- ADDR_WIDTH, 32, AXADDR width in bits.
- MEM_BYTES, 16, memory size in bytes; power of two, at least DATA_WIDTH/8.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write address (byte).
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte-lane enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_WIDTH  read address (byte).
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

Behaviour:
- Reset (ARESET=1 at an edge): AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, BRESP=00, RVALID=0, RRESP=00, RDATA=0. Both holding registers are emptied. Memory contents are not cleared.
- Reset mid-transaction discards any uncommitted AW/W/AR and any pending B/R. No memory write occurs for an uncommitted transaction.
- Handshake: a transfer occurs on a rising edge where VALID and READY are both 1. The slave never waits for VALID before asserting READY.
- AW holding register (addr + full flag): AWREADY = !aw_full && !ARESET.
- W holding register (data, strb + full flag): WREADY = !w_full && !ARESET.
- AW and W may arrive in either order or together; each is accepted independently.
- Write commit: occurs at the edge where aw_full && w_full && (!BVALID || BREADY). At that edge:
  - memory is updated;
  - both full flags clear;
  - BVALID=1 and BRESP are set.
- Latency: with AW and W accepted at edge N and B idle, commit happens at edge N+1, so BVALID is high after N+1.
- Address decode: word index = addr[log2(MEM_BYTES)-1 : log2(STRB)]. Low byte-offset bits are ignored (forced alignment).
- In range (addr < MEM_BYTES): for each lane i with WSTRB[i]=1, mem byte (index*STRB + i) <= WDATA[8i+7:8i]. BRESP=00 (OKAY). WSTRB=0 writes nothing and still returns OKAY.
- Out of range (addr >= MEM_BYTES): no write, BRESP=10 (SLVERR).
- B backpressure: BVALID and BRESP stay stable until BREADY. While the B slot is occupied, a full AW/W pair waits, and AWREADY/WREADY stay low for any full register.
- Read path, one outstanding: ARREADY = !RVALID && !ARESET (also low for the cycle in which an R handshake completes). AR handshake at edge N sets RVALID=1 at N, with RDATA = addressed word and RRESP=00.
- Read out of range: RDATA=0, RRESP=10.
- R backpressure: RVALID, RDATA and RRESP are held stable until RREADY. RVALID clears on the R handshake edge.
- Read and commit at the same edge to the same word: RDATA returns pre-write contents.
- Read and write paths are fully independent; neither stalls the other.

Decomposition:
- Shared package axi_pkg holds:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - a function computing log2 for index widths.
- One sub-module, axi_byte_ram: MEM_BYTES/STRB words x DATA_WIDTH, per-byte write enable, one write port, one read port with synchronous read-before-write.
- Handshake and response logic stays in axi_lite_slave_mem.

Test Plan:
- Reset, then idle: AWREADY=WREADY=ARREADY=1 on the first cycle after ARESET falls. BVALID=RVALID=0, BRESP=RRESP=00.
- AW(0x4) and W(0xDEADBEEF, STRB=1111) in the same cycle, BREADY=1 → BVALID one cycle later with BRESP=00. Then AR(0x4) returns RDATA=0xDEADBEEF, RRESP=00.
- W before AW: W(0x11223344, STRB=0101) at cycle 0, AW(0x8) at cycle 3. Expect WREADY=0 during cycles 1–3. Read of 0x8 → 0x00220044 (from zero-initialised words).
- Out-of-range AW(0x10), W(0xFFFFFFFF) → BRESP=10, no memory change. AR(0x20) → RVALID with RDATA=0, RRESP=10.
- Backpressure: BREADY=0 for 5 cycles → BVALID and BRESP stable; a second AW/W pair is held (AWREADY=WREADY=0) and commits on the edge BREADY=1. Same check for RREADY=0 → RDATA stable, ARREADY=0.
- Reset mid-op: AW accepted, ARESET pulsed before W arrives → no write. Subsequent read of that address returns its old value; all outputs show reset values during the pulse.

Source files
------------

// File: rtl/axi_pkg.sv
// +------------------------------------------------------------------------+
// | axi_pkg: shared AXI response codes and an index-width helper.          |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Floor log2; exact for the power-of-two sizes used as index widths.
  function automatic int axi_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= n) r = i;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_byte_ram.sv
// +------------------------------------------------------------------------+
// | axi_byte_ram: word-organised RAM with per-byte write enables and a     |
// | synchronous read port that returns pre-write data on a collision.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module axi_byte_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4,
  parameter int IDX_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [IDX_W-1:0]        i_widx,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [IDX_W-1:0]        i_ridx,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int C_LANES = DATA_WIDTH / 8;

  // One byte-wide array per lane keeps every lane's storage single-driven.
  for (genvar g = 0; g < C_LANES; g++) begin : g_lane
    logic [7:0] r_mem [WORDS];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
      if (i_we && i_wstrb[g]) r_mem[i_widx] <= i_wdata[8*g +: 8];
      if (rst)       r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_ridx];
    end

    assign o_rdata[8*g +: 8] = r_rdata;
  end

endmodule

`default_nettype wire

// File: rtl/axi_lite_slave_mem.sv
// +------------------------------------------------------------------------+
// | axi_lite_slave_mem: AXI4-Lite slave fronting a byte-addressed RAM,     |
// | with independent AW/W holding registers and one outstanding read.      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module axi_lite_slave_mem
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int C_STRB_W = DATA_WIDTH / 8;
  localparam int C_WORDS  = MEM_BYTES / C_STRB_W;
  localparam int C_LSB    = axi_log2(C_STRB_W);
  localparam int C_IDX_W  = (C_WORDS > 1) ? axi_log2(C_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] C_MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

  logic                  r_aw_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic                  r_w_full;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [C_STRB_W-1:0]   r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic                  r_rd_err;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic                  w_aw_in_range;
  logic                  w_ar_in_range;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign AWREADY = !r_aw_full && !ARESET;
  assign WREADY  = !r_w_full && !ARESET;
  assign ARREADY = !r_rvalid && !ARESET;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign RVALID  = r_rvalid;
  assign RRESP   = r_rresp;
  // Out-of-range reads still strobe the RAM; the error flag masks the word.
  assign RDATA   = r_rd_err ? '0 : w_ram_rdata;

  assign w_aw_hs       = AWVALID && AWREADY;
  assign w_w_hs        = WVALID && WREADY;
  assign w_ar_hs       = ARVALID && ARREADY;
  assign w_commit      = r_aw_full && r_w_full && (!r_bvalid || BREADY);
  assign w_aw_in_range = r_aw_addr < C_MEM_LIMIT;
  assign w_ar_in_range = ARADDR < C_MEM_LIMIT;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rd_err  <= 1'b0;
    end else begin
      if (w_commit) begin
        r_aw_full <= 1'b0;
      end else if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= AWADDR;
      end

      if (w_commit) begin
        r_w_full <= 1'b0;
      end else if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= WDATA;
        r_wstrb  <= WSTRB;
      end

      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (BREADY) begin
        r_bvalid <= 1'b0;
      end

      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
        r_rd_err <= !w_ar_in_range;
      end else if (RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  axi_byte_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (C_WORDS),
    .IDX_W      (C_IDX_W)
  ) u_ram (
    .clk     (ACLK),
    .rst     (ARESET),
    .i_we    (w_commit && w_aw_in_range),
    .i_wstrb (r_wstrb),
    .i_widx  (r_aw_addr[C_LSB +: C_IDX_W]),
    .i_wdata (r_wdata),
    .i_re    (w_ar_hs),
    .i_ridx  (ARADDR[C_LSB +: C_IDX_W]),
    .o_rdata (w_ram_rdata)
  );

endmodule

`default_nettype wire
